pipelined_seg_adder: RTL and testbench
======================================

PIPELINED_SEG_ADDER -- requirements
Module: pipelined_seg_adder

Interface
REQ-001 Parameter WIDTH, default 512: operand and sum width in bits.
REQ-002 Parameter SEG, default 128: segment width; WIDTH SHALL be an integer multiple of SEG, and SEG SHALL be a multiple of 4.
REQ-003 Derived constant NSEG = WIDTH/SEG, default 4: pipeline depth.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 in_a  input  WIDTH  operand A (unsigned / two's complement).
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 in_ci  input  1  carry-in; used only in add mode.
REQ-011 in_sub  input  1  0 = A+B+ci; 1 = A-B.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 out_cout  output  1  carry out of bit WIDTH-1; in subtract mode 1 means no borrow.
REQ-016 out_ovf  output  1  signed two's-complement overflow.

Function
REQ-017 Handshake: a beat transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
REQ-018 Subtract: effective B = ~in_b with carry-in forced to 1; in_ci is ignored.
REQ-019 Stage k (k = 0..NSEG-1) adds segment k, bits [k*SEG +: SEG], using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-020 Input skew: segment k of A, effective B and the mode bit are delayed k register stages before stage k uses them.
REQ-021 Output deskew: the sum of segment k is delayed NSEG-1-k register stages, so all segments of a beat appear on out_sum together.
REQ-022 Latency is exactly NSEG cycles from acceptance to out_valid when not stalled; for example, accepted at cycle t gives out_valid at t+4 with the defaults.
REQ-023 Throughput is one beat per cycle; back-to-back beats are never reordered or merged.
REQ-024 Each stage carries a valid bit; out_valid equals the final-stage valid bit.
REQ-025 Stall: when out_valid && !out_ready, every pipeline register, including the skew and deskew registers, holds its value.
REQ-026 in_ready = !(out_valid && !out_ready); it is combinational from out_ready, and there is no other combinational path from inputs to outputs.
REQ-027 Bubbles: when in_valid is 0, a stage-0 valid bit of 0 enters the pipeline; bubbles advance without stalling.
REQ-028 While out_valid && !out_ready, out_sum, out_cout and out_ovf SHALL stay stable.
REQ-029 out_ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), evaluated in the final stage.
REQ-030 Wrap-around: the sum is truncated to WIDTH bits, and the carry is reported only on out_cout.
REQ-031 Each segment's carry-propagate logic SHALL be carry-lookahead (group P/G); ripple across a full segment is not permitted.

Reset
REQ-032 With rst high at a clock edge, all valid bits, out_valid, out_sum, out_cout and out_ovf clear to 0.
REQ-033 in_ready is 1 in the cycle after reset.
REQ-034 Reset during operation discards every in-flight beat; no partial result is emitted.
REQ-035 rst has priority over a simultaneous handshake; a beat offered in the reset cycle is not accepted.

Structure
REQ-036 A shared package pipelined_seg_adder_pkg holds the defaults WIDTH_DEF=512 and SEG_DEF=128.
REQ-037 The package also holds the function nseg(width, seg) and the mode constants MODE_ADD=0 and MODE_SUB=1.
REQ-038 One sub-module, cla_seg (parameter SEG), provides the combinational SEG-bit lookahead adder: inputs a, b, ci; outputs s, cout, pout, gout.
REQ-039 cla_seg SHALL be instantiated NSEG times via generate.
REQ-040 The top level contains only registers, the handshake logic and the cla_seg instances.

Verification
REQ-041 Add carry chain: A = all ones, B = 0, ci = 1, add mode, out_ready = 1 -> exactly 4 cycles later out_sum = 0, out_cout = 1, out_ovf = 0.
REQ-042 Subtract: A = 0, B = 1, in_sub = 1 -> out_sum = all ones, out_cout = 0; then A = 5, B = 3 -> out_sum = 2, out_cout = 1.
REQ-043 Signed overflow: A = 0x7FF..F, B = 1, add mode -> out_sum = 0x800..0, out_ovf = 1, out_cout = 0.
REQ-044 Streaming with backpressure: 8 back-to-back random beats with out_ready low for 3 cycles mid-stream -> results match the golden model in order, with no loss or duplication, outputs stable while stalled, and in_ready low exactly during the stall.
REQ-045 Reset mid-flight: assert rst for 1 cycle 2 cycles after accepting 2 beats -> out_valid never rises for those beats, and a new beat accepted afterwards emerges after 4 cycles correctly.
REQ-046 Parameter sweep: WIDTH = 64 with SEG = 16, and WIDTH = 128 with SEG = 128 (NSEG = 1) -> latencies of 4 and 1 cycles, and random beats match the golden model.

Source files
------------

// File: rtl/pipelined_seg_adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
// Defaults give a 512-bit adder split into four 128-bit stages.
package pipelined_seg_adder_pkg;

  localparam int WIDTH_DEF = 512;
  localparam int SEG_DEF   = 128;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipelined_seg_adder_cla.sv
// Combinational SEG-bit carry-lookahead adder.
// Two levels: 4-bit groups, then flattened lookahead across groups.
module cla_seg #(
  parameter int SEG = 128
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           pout,
  output logic           gout
);

  localparam int NG = SEG / 4;

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [NG-1:0]  gp;
  logic [NG-1:0]  gg;
  logic [NG:0]    gc;
  logic           gacc;
  logic           gpp;
  logic           bacc;
  logic           bpp;

  assign p    = a ^ b;
  assign g    = a & b;
  assign cout = gc[NG];

  // per-group propagate and generate
  always_comb begin
    gp = '0;
    gg = '0;
    for (int i = 0; i < NG; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (&p[4*i+2 +: 2] & g[4*i+1])
            | (&p[4*i+1 +: 3] & g[4*i]);
    end
  end

  // carry into each group, expanded as a sum of products
  always_comb begin
    gc    = '0;
    gc[0] = ci;
    gacc  = 1'b0;
    gpp   = 1'b1;
    for (int i = 1; i <= NG; i++) begin
      gacc = 1'b0;
      gpp  = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        gacc = gacc | (gg[j] & gpp);
        gpp  = gpp & gp[j];
      end
      gc[i] = gacc | (gpp & ci);
    end
  end

  // segment-level propagate and generate
  always_comb begin
    gout = 1'b0;
    pout = 1'b1;
    for (int j = NG - 1; j >= 0; j--) begin
      gout = gout | (gg[j] & pout);
      pout = pout & gp[j];
    end
  end

  // bit carries inside each group, then sum bits
  always_comb begin
    s    = '0;
    bacc = 1'b0;
    bpp  = 1'b1;
    for (int i = 0; i < NG; i++) begin
      for (int k = 0; k < 4; k++) begin
        bacc = 1'b0;
        bpp  = 1'b1;
        for (int j = k - 1; j >= 0; j--) begin
          bacc = bacc | (g[4*i+j] & bpp);
          bpp  = bpp & p[4*i+j];
        end
        s[4*i+k] = p[4*i+k] ^ (bacc | (bpp & gc[i]));
      end
    end
  end

endmodule

// File: rtl/pipelined_seg_adder.sv
// Segment-pipelined adder/subtractor with valid/ready handshake.
// Operands are skewed in, one segment per stage, sums deskewed out.
module pipelined_seg_adder
  import pipelined_seg_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = nseg(WIDTH, SEG);

  logic                      en;
  logic [WIDTH-1:0]          b_eff;
  logic                      c0;
  logic [NSEG-1:0]           v_q;
  logic [NSEG-1:0]           v_d;
  logic [NSEG-1:0]           c_reg;
  logic [NSEG-1:0]           cin;
  logic [NSEG-1:0]           co;
  logic [NSEG-1:0]           seg_p;
  logic [NSEG-1:0]           seg_g;
  logic [NSEG-1:0][SEG-1:0]  a_use;
  logic [NSEG-1:0][SEG-1:0]  b_use;
  logic [NSEG-1:0][SEG-1:0]  s_cmb;
  logic [NSEG-1:0][SEG-1:0]  s_out;
  logic                      ovf_q;
  logic                      ovf_d;
  logic                      unused_pg;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign b_eff    = (in_sub == MODE_SUB) ? ~in_b : in_b;
  assign c0       = (in_sub == MODE_SUB) ? 1'b1 : in_ci;

  assign out_valid = v_q[NSEG-1];
  assign out_sum   = s_out;
  assign out_cout  = c_reg[NSEG-1];
  assign out_ovf   = ovf_q;

  assign unused_pg = ^{seg_p, seg_g};

  assign ovf_d =
    (a_use[NSEG-1][SEG-1] == b_use[NSEG-1][SEG-1]) &&
    (s_cmb[NSEG-1][SEG-1] != a_use[NSEG-1][SEG-1]);

  // next valid vector: new beat or bubble enters stage 0
  always_comb begin
    v_d    = v_q;
    v_d[0] = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      v_d[k] = v_q[k-1];
    end
  end

  // valid bits advance only when the pipe is not stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= v_d;
    end
  end

  // overflow flag judged by the last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int DLY = NSEG - 1 - k;

    logic [SEG-1:0] s_q;
    logic           c_q;

    if (k == 0) begin : g_in
      assign a_use[k] = in_a[0 +: SEG];
      assign b_use[k] = b_eff[0 +: SEG];
      assign cin[k]   = c0;
    end else begin : g_skew
      logic [SEG-1:0] a_sk_q [k];
      logic [SEG-1:0] b_sk_q [k];

      // delay segment k operands by k stages
      always_ff @(posedge clk) begin
        if (en) begin
          a_sk_q[0] <= in_a[k*SEG +: SEG];
          b_sk_q[0] <= b_eff[k*SEG +: SEG];
          for (int j = 1; j < k; j++) begin
            a_sk_q[j] <= a_sk_q[j-1];
            b_sk_q[j] <= b_sk_q[j-1];
          end
        end
      end

      assign a_use[k] = a_sk_q[k-1];
      assign b_use[k] = b_sk_q[k-1];
      assign cin[k]   = c_reg[k-1];
    end

    cla_seg #(
      .SEG(SEG)
    ) u_cla (
      .a    (a_use[k]),
      .b    (b_use[k]),
      .ci   (cin[k]),
      .s    (s_cmb[k]),
      .cout (co[k]),
      .pout (seg_p[k]),
      .gout (seg_g[k])
    );

    // stage result and carry handed to the next stage
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        s_q <= s_cmb[k];
        c_q <= co[k];
      end
    end

    assign c_reg[k] = c_q;

    if (DLY == 0) begin : g_nodsk
      assign s_out[k] = s_q;
    end else begin : g_dsk
      logic [SEG-1:0] ds_q [DLY];

      // hold early segments until the last one is done
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DLY; j++) begin
            ds_q[j] <= '0;
          end
        end else if (en) begin
          ds_q[0] <= s_q;
          for (int j = 1; j < DLY; j++) begin
            ds_q[j] <= ds_q[j-1];
          end
        end
      end

      assign s_out[k] = ds_q[DLY-1];
    end
  end

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Scoreboard bench: three adder configurations, reference model
// from plain wide arithmetic, monitor pops on each output beat.
module tb_pipelined_seg_adder;

  typedef struct {
    logic [511:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           chk;
    int           dut;
  } exp_t;

  int WD  [3] = '{512, 64, 128};
  int LAT [3] = '{4, 4, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         oc   [3];
  logic         oo   [3];
  logic [511:0] os   [3];
  logic [511:0] ia;
  logic [511:0] ib;
  logic         ici;
  logic         isub;
  logic [63:0]  s1;
  logic [127:0] s2;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   chk_lat  = 1'b1;
  bit   rdone    = 1'b0;
  exp_t sbq [$];

  bit           held [3];
  logic [511:0] hs   [3];
  logic         hc   [3];
  logic         ho   [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_seg_adder #(.WIDTH(512), .SEG(128)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia), .in_b(ib), .in_ci(ici), .in_sub(isub),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(os[0]), .out_cout(oc[0]), .out_ovf(oo[0])
  );

  pipelined_seg_adder #(.WIDTH(64), .SEG(16)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[63:0]), .in_b(ib[63:0]),
    .in_ci(ici), .in_sub(isub),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(s1), .out_cout(oc[1]), .out_ovf(oo[1])
  );

  pipelined_seg_adder #(.WIDTH(128), .SEG(128)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[127:0]), .in_b(ib[127:0]),
    .in_ci(ici), .in_sub(isub),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(s2), .out_cout(oc[2]), .out_ovf(oo[2])
  );

  assign os[1] = {448'd0, s1};
  assign os[2] = {384'd0, s2};

  function automatic exp_t model(input int w,
                                 input logic [511:0] a,
                                 input logic [511:0] b,
                                 input logic ci,
                                 input logic sub);
    logic [512:0] one;
    logic [512:0] mask;
    logic [512:0] aa;
    logic [512:0] bb;
    logic [512:0] t;
    logic         sa;
    logic         sb;
    logic         ss;
    exp_t         e;
    one  = 513'd1;
    mask = (one << w) - one;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, b} & mask;
    if (!sub) begin
      t      = aa + bb + {512'd0, ci};
      e.cout = t[w];
    end else begin
      t      = aa - bb;
      e.cout = (aa >= bb);
    end
    t     = t & mask;
    e.sum = t[511:0];
    sa    = aa[w-1];
    sb    = bb[w-1];
    ss    = t[w-1];
    if (!sub) e.ovf = (sa == sb) && (ss != sa);
    else      e.ovf = (sa != sb) && (ss != sa);
    e.acc = 0;
    e.chk = 1'b0;
    e.dut = 0;
    return e;
  endfunction

  function automatic logic [511:0] pat();
    logic [511:0] r;
    int           k;
    k = $urandom_range(0, 5);
    r = '0;
    if (k == 0) begin
      r = '1;
    end else if (k == 1) begin
      r[0] = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  task automatic send(input int d,
                      input logic [511:0] a,
                      input logic [511:0] b,
                      input logic ci,
                      input logic sub);
    int   n;
    exp_t e;
    ia    = a;
    ib    = b;
    ici   = ci;
    isub  = sub;
    iv[d] = 1'b1;
    n     = 0;
    @(negedge clk);
    while (!ir[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir[d]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d in_ready=%b need=1",
               d, ir[d]);
    end else begin
      e     = model(WD[d], a, b, ci, sub);
      e.acc = cyc;
      e.chk = chk_lat;
      e.dut = d;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d need=0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || os[d] !== '0 ||
          oc[d] !== 1'b0 || oo[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d v=%b rdy=%b c=%b o=%b sum=%h need v=0 rdy=1 c=0 o=0 sum=0",
                 d, ov[d], ir[d], oc[d], oo[d], os[d]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: handshake rule, stall stability, scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int d = 0; d < 3; d++) held[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (ir[d] !== !(ov[d] && !ordy[d])) begin
          failures++;
          $display("FAIL in_ready dut%0d got=%b need=%b",
                   d, ir[d], !(ov[d] && !ordy[d]));
        end
        if (held[d]) begin
          checks++;
          if (ov[d] !== 1'b1 || os[d] !== hs[d] ||
              oc[d] !== hc[d] || oo[d] !== ho[d]) begin
            failures++;
            $display("FAIL stall_hold dut%0d v=%b sum=%h need v=1 sum=%h",
                     d, ov[d], os[d], hs[d]);
          end
        end
        held[d] = ov[d] && !ordy[d];
        hs[d]   = os[d];
        hc[d]   = oc[d];
        ho[d]   = oo[d];
        if (ov[d]) begin
          if (sbq.size() == 0 || sbq[0].dut != d) begin
            checks++;
            failures++;
            $display("FAIL spurious_valid dut%0d out_valid=1 need=0", d);
          end else if (ordy[d]) begin
            e = sbq.pop_front();
            checks++;
            if (os[d] !== e.sum || oc[d] !== e.cout ||
                oo[d] !== e.ovf) begin
              failures++;
              $display("FAIL result dut%0d sum=%h c=%b o=%b need sum=%h c=%b o=%b",
                       d, os[d], oc[d], oo[d], e.sum, e.cout, e.ovf);
            end
            if (e.chk) begin
              checks++;
              if (cyc - e.acc != LAT[d]) begin
                failures++;
                $display("FAIL latency dut%0d got=%0d need=%0d",
                         d, cyc - e.acc, LAT[d]);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] mx;
    rst  = 1'b1;
    ia   = '0;
    ib   = '0;
    ici  = 1'b0;
    isub = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      held[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset();

    // directed: carry chain, subtract, signed overflow
    chk_lat = 1'b1;
    send(0, '1, '0, 1'b1, 1'b0);
    send(0, 512'd0, 512'd1, 1'b0, 1'b1);
    send(0, 512'd5, 512'd3, 1'b0, 1'b1);
    send(0, 512'd5, 512'd3, 1'b1, 1'b1);
    mx      = '1;
    mx[511] = 1'b0;
    send(0, mx, 512'd1, 1'b0, 1'b0);
    send(0, mx, 512'd1, 1'b1, 1'b0);
    drain();

    // streaming with a three-cycle backpressure window
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(0, pat(), pat(), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
    join
    drain();

    // random gaps and random out_ready
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(0, pat(), pat(), 1'($urandom), 1'($urandom));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          ordy[0] = ($urandom_range(0, 3) != 0);
        end
        ordy[0] = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight and a beat offered
    chk_lat = 1'b1;
    send(0, pat(), pat(), 1'b0, 1'b0);
    send(0, pat(), pat(), 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    iv[0] = 1'b1;
    ia    = pat();
    ib    = pat();
    sbq.delete();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    iv[0] = 1'b0;
    chk_reset();
    repeat (6) @(posedge clk);
    #1;
    send(0, 512'd100, 512'd23, 1'b1, 1'b0);
    drain();

    // smaller configurations: 64/16 and 128/128
    for (int d = 1; d < 3; d++) begin
      send(d, '1, '0, 1'b1, 1'b0);
      send(d, '0, 512'd1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++)
        send(d, pat(), pat(), 1'($urandom), 1'($urandom));
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
